// File: rtl/btn_toggle_conditioner.sv
// Push-button conditioner: synchronises and debounces a raw button and emits
// a single-cycle toggle-enable pulse T per accepted press, plus level and count.
module btn_toggle_conditioner #(
  parameter int DB_CYCLES   = 16,
  parameter bit ACTIVE_HIGH = 1'b1,
  parameter int CNT_W       = ($clog2(DB_CYCLES) < 1) ? 1 : $clog2(DB_CYCLES)
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       btn_in,
  input  logic       enable,
  output logic       T,
  output logic       level,
  output logic [7:0] press_count
);

  typedef enum logic [1:0] {
    IDLE,
    PRESS_WAIT,
    PRESSED,
    RELEASE_WAIT
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

  logic             btn_norm;
  logic             s1;
  logic             s2;
  state_t           state_q;
  state_t           state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             t_d;
  logic             level_d;
  logic [7:0]       count_d;

  // Fold polarity in before the synchroniser so everything downstream sees 1 = pressed.
  assign btn_norm = btn_in ^ ~ACTIVE_HIGH;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values, regardless of the order the simulator evaluates blocks.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= btn_norm;
      s2 <= s1;
    end
  end

  // NOTE: every variable gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    t_d     = 1'b0;
    level_d = level;
    count_d = press_count;

    unique case (state_q)
      IDLE: begin
        if (s2) begin
          state_d = PRESS_WAIT;
          cnt_d   = '0;
        end
      end

      PRESS_WAIT: begin
        if (!s2) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = PRESSED;
          level_d = 1'b1;
          t_d     = enable;
          if (enable) begin
            count_d = press_count + 8'd1;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      PRESSED: begin
        if (!s2) begin
          state_d = RELEASE_WAIT;
          cnt_d   = '0;
        end
      end

      RELEASE_WAIT: begin
        if (s2) begin
          state_d = PRESSED;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = IDLE;
          level_d = 1'b0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      T           <= 1'b0;
      level       <= 1'b0;
      press_count <= 8'd0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      T           <= t_d;
      level       <= level_d;
      press_count <= count_d;
    end
  end

endmodule

// File: tb/tb_btn_toggle_conditioner.sv
// Bench for btn_toggle_conditioner: directed presses, bounces, gating, reset and
// wrap, checked every cycle against a run-length debounce model.
module tb_btn_toggle_conditioner;

  localparam int DB_A = 8;
  localparam int DB_B = 4;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic       btn_a = 1'b0;
  logic       btn_b = 1'b1;
  logic       enable = 1'b1;
  logic       t_a, level_a, t_b, level_b;
  logic [7:0] count_a, count_b;

  int n_checks = 0;
  int n_fail   = 0;
  int nb_pulses = 0;

  // Model state per instance: two-stage sample delay, debounced level, length of
  // the current run of samples that disagree with it, pulse and press count.
  bit m_s1 [2];
  bit m_s2 [2];
  bit m_level [2];
  int m_run [2];
  bit m_t [2];
  int m_cnt [2];

  btn_toggle_conditioner #(.DB_CYCLES(DB_A), .ACTIVE_HIGH(1'b1)) dut_a (
    .clock(clk), .reset(rst_n), .btn_in(btn_a), .enable(enable),
    .T(t_a), .level(level_a), .press_count(count_a)
  );

  btn_toggle_conditioner #(.DB_CYCLES(DB_B), .ACTIVE_HIGH(1'b0)) dut_b (
    .clock(clk), .reset(rst_n), .btn_in(btn_b), .enable(enable),
    .T(t_b), .level(level_b), .press_count(count_b)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail <= 40) $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic model_clear(input int i);
    m_s1[i] = 0; m_s2[i] = 0; m_level[i] = 0; m_run[i] = 0; m_t[i] = 0; m_cnt[i] = 0;
  endtask

  // A level change is accepted once db+1 consecutive synchronised samples all
  // disagree with the current level; only an accepted press may pulse.
  task automatic model_step(input int i, input bit pressed, input bit en);
    int db;
    bit sample;
    db = (i == 0) ? DB_A : DB_B;
    sample = m_s2[i];
    m_s2[i] = m_s1[i];
    m_s1[i] = pressed;
    m_t[i] = 0;
    if (sample != m_level[i]) m_run[i]++;
    else m_run[i] = 0;
    if (m_run[i] == db + 1) begin
      m_level[i] = sample;
      m_run[i] = 0;
      if (sample && en) begin
        m_t[i] = 1;
        m_cnt[i] = (m_cnt[i] + 1) % 256;
      end
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) model_clear(0);
    else model_step(0, btn_a, enable);
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) model_clear(1);
    else model_step(1, ~btn_b, enable);
  end

  always @(negedge clk) begin
    check("t_a", {31'd0, t_a}, {31'd0, m_t[0]});
    check("level_a", {31'd0, level_a}, {31'd0, m_level[0]});
    check("count_a", {24'd0, count_a}, m_cnt[0]);
    check("t_b", {31'd0, t_b}, {31'd0, m_t[1]});
    check("level_b", {31'd0, level_b}, {31'd0, m_level[1]});
    check("count_b", {24'd0, count_b}, m_cnt[1]);
    if (t_b === 1'b1) nb_pulses++;
  end

  initial begin
    tick(3);
    check("rst_t_a", {31'd0, t_a}, 32'd0);
    check("rst_level_a", {31'd0, level_a}, 32'd0);
    check("rst_count_a", {24'd0, count_a}, 32'd0);
    check("rst_count_b", {24'd0, count_b}, 32'd0);

    // Clean press: pressed value sampled from edge 0, pulse after edge 10.
    rst_n = 1'b1;
    btn_a = 1'b1;
    tick(10);
    check("clean_t_before", {31'd0, t_a}, 32'd0);
    check("clean_level_before", {31'd0, level_a}, 32'd0);
    tick(1);
    check("clean_t", {31'd0, t_a}, 32'd1);
    check("clean_level", {31'd0, level_a}, 32'd1);
    check("clean_count", {24'd0, count_a}, 32'd1);
    tick(1);
    check("clean_t_fall", {31'd0, t_a}, 32'd0);
    tick(20);
    check("hold_no_repeat", {24'd0, count_a}, 32'd1);

    // Release: level falls after edge 10 of the release, then a second press.
    btn_a = 1'b0;
    tick(10);
    check("release_level_before", {31'd0, level_a}, 32'd1);
    tick(1);
    check("release_level", {31'd0, level_a}, 32'd0);
    check("release_no_pulse", {31'd0, t_a}, 32'd0);
    tick(1);
    btn_a = 1'b1;
    tick(11);
    check("second_t", {31'd0, t_a}, 32'd1);
    check("second_count", {24'd0, count_a}, 32'd2);
    btn_a = 1'b0;
    tick(14);

    // Bounce 1,0,1,0 at 3-cycle spacing, then hold.
    for (int k = 0; k < 4; k++) begin
      btn_a = (k % 2 == 0);
      tick(3);
    end
    check("bounce_level", {31'd0, level_a}, 32'd0);
    btn_a = 1'b1;
    tick(10);
    check("bounce_t_before", {31'd0, t_a}, 32'd0);
    tick(1);
    check("bounce_t", {31'd0, t_a}, 32'd1);
    check("bounce_count", {24'd0, count_a}, 32'd3);
    btn_a = 1'b0;
    tick(14);

    // Enable gating: level follows, no pulse, count held; late enable has no effect.
    enable = 1'b0;
    btn_a = 1'b1;
    tick(11);
    check("gated_level", {31'd0, level_a}, 32'd1);
    check("gated_t", {31'd0, t_a}, 32'd0);
    enable = 1'b1;
    tick(5);
    check("gated_count", {24'd0, count_a}, 32'd3);
    btn_a = 1'b0;
    tick(14);

    // Reset in the middle of PRESS_WAIT with the button held.
    btn_a = 1'b1;
    tick(8);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_t", {31'd0, t_a}, 32'd0);
    check("midrst_level", {31'd0, level_a}, 32'd0);
    check("midrst_count", {24'd0, count_a}, 32'd0);
    tick(2);
    rst_n = 1'b1;
    tick(10);
    check("midrst_t_before", {31'd0, t_a}, 32'd0);
    tick(1);
    check("midrst_t_after", {31'd0, t_a}, 32'd1);
    check("midrst_count_after", {24'd0, count_a}, 32'd1);
    btn_a = 1'b0;
    tick(14);

    // Active-low instance: 256 clean presses wrap the count back to 0.
    nb_pulses = 0;
    for (int i = 0; i < 256; i++) begin
      btn_b = 1'b0;
      tick(8);
      btn_b = 1'b1;
      tick(8);
      if (i == 0) check("wrap_first", {24'd0, count_b}, 32'd1);
      if (i == 254) check("wrap_255", {24'd0, count_b}, 32'd255);
    end
    check("wrap_count", {24'd0, count_b}, 32'd0);
    check("wrap_pulses", nb_pulses, 32'd256);
    check("wrap_model", m_cnt[1], 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/btn_toggle_conditioner.md
# btn_toggle_conditioner

- Conditions a raw, bouncing push-button into a clean, single-cycle toggle-enable pulse `T` for the downstream toggle flip-flop stage.
- Internals: a two-flop synchroniser, a debounce counter and a four-state FSM.
- Also exports the debounced button level and a wrapping count of emitted pulses.
- Runs on the rising edge of `clock`, so `T` is stable for half a cycle before the toggle flip-flop samples it on the falling edge.

## Interface
- `DB_CYCLES`, default 16: number of consecutive stable synchronised samples needed to accept a level change. Legal range 2..65535.
- `ACTIVE_HIGH`, default 1: 1 means `btn_in`=1 is pressed; 0 means `btn_in`=0 is pressed.
- `CNT_W`, default `$clog2(DB_CYCLES)`, minimum 1: width of the debounce counter. Derived; do not override.
- `clock` input, 1 bit: single system clock. All state updates on the rising edge.
- `reset` input, 1 bit: asynchronous, active-low reset.
- `btn_in` input, 1 bit: raw button. It is asynchronous to `clock` and may bounce.
- `enable` input, 1 bit: when 0, suppresses `T` pulses. Debouncing continues regardless.
- `T` output, 1 bit: registered one-cycle pulse on each accepted press.
- `level` output, 1 bit: registered debounced state; 1 = pressed.
- `press_count` output, 8 bits: number of `T` pulses emitted. Wraps 255 -> 0.

## Operation
- Input polarity: `btn_in` is XOR-ed with `~ACTIVE_HIGH` before the synchroniser, so internally 1 = pressed.
- Synchroniser: `s1 <= in`, `s2 <= s1`. Only `s2` feeds the FSM.
- FSM states: IDLE (stable released), PRESS_WAIT, PRESSED (stable pressed), RELEASE_WAIT.
- IDLE:
  - `s2`=1 -> PRESS_WAIT, `cnt` <= 0.
  - Otherwise stay.
- PRESS_WAIT:
  - `s2`=0 -> IDLE, `cnt` <= 0. This is a bounce; no outputs change.
  - `s2`=1 and `cnt`==DB_CYCLES-1 -> PRESSED, `level` <= 1, `T` <= `enable`. If `enable`=1, also `press_count` <= `press_count`+1 (mod 256).
  - `s2`=1 otherwise -> `cnt` <= `cnt`+1.
- PRESSED:
  - `s2`=0 -> RELEASE_WAIT, `cnt` <= 0.
  - Otherwise stay.
- RELEASE_WAIT:
  - `s2`=1 -> PRESSED, `cnt` <= 0.
  - `s2`=0 and `cnt`==DB_CYCLES-1 -> IDLE, `level` <= 0.
  - Otherwise `cnt` <= `cnt`+1.
  - No pulse is ever generated on release.
- `T` defaults to 0 on every edge not listed above, so it is high for exactly one cycle per accepted press.
- Reset (`reset`=0, asynchronous) clears:
  - `s1`, `s2`, `cnt`, `T`, `level`, `press_count` -> 0.
  - state -> IDLE.
- Reset mid-debounce discards the partial count and emits no pulse.
- A button still held when `reset` deasserts is treated as a new press: full latency, then one pulse.
- `enable` is sampled only on the PRESS_WAIT -> PRESSED edge. Changing it at any other time has no effect on pulses already accepted or suppressed.
- Holding the button emits exactly one pulse. There is no auto-repeat.

## Timing
- Let edge k be the first rising edge at which `btn_in` is sampled in its pressed value and then held:
  - `s2`=1 after edge k+1.
  - PRESS_WAIT entered at edge k+2.
  - `T` and `level` rise after edge k+2+DB_CYCLES.
  - `T` falls after edge k+3+DB_CYCLES.
- Release timing mirrors press timing: `level` falls DB_CYCLES+2 edges after the first released sample.
- Any opposite-value sample during a WAIT state restarts qualification from zero once the input settles.
- The minimum `btn_in` pulse width guaranteed to be accepted is DB_CYCLES+1 clock periods.
- `T` is a flop output driven on the rising edge. Downstream falling-edge logic therefore sees half a period of setup.
- Reset deassertion should be synchronous to `clock` at the top level. The downstream toggle flip-flop uses an active-high synchronous reset, so the top level inverts `reset` for it.

## Test plan
- Clean press, DB_CYCLES=8: reset, then hold `btn_in`=1 from edge 0. Required: `T`=1 only in the cycle after edge 10, `level`=1 from edge 10, `press_count`=1.
- Bounce, DB_CYCLES=8: `btn_in` toggles 1,0,1,0 with 3-cycle spacing, then holds 1. Required: exactly one `T` pulse, occurring 10 edges after the final rising sample, and `press_count`=1.
- Release and repeat: after an accepted press, drop `btn_in` for 12 cycles, then press again. Required: `level` falls 10 edges after the release, a second `T` pulse on the second press, and `press_count`=2. No pulse on release.
- Enable gating: `enable`=0 during a press. Required: `level` rises, `T` stays 0, `press_count` unchanged.
- Reset mid-debounce: assert `reset`=0 at edge 5 of PRESS_WAIT with the button held, release reset 2 cycles later. Required: all outputs 0 immediately on assertion, then one pulse DB_CYCLES+2 edges after reset release.
- Wrap and polarity: ACTIVE_HIGH=0, 256 clean presses (`btn_in` driven low). Required: 256 pulses and `press_count` returns to 0.
